decode_pipe_nlane: RTL and testbench

//  Registered, parametrised N-lane decode stage between instruction fetch and the I-buffer/SIMT stack.

---
 rtl/decode_pipe_nlane.sv | 213 +++++++++++++++++++++
 tb/tb_decode_pipe_nlane.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe_nlane.sv
// decode_pipe_nlane: N-lane registered decode stage between fetch and the I-buffer.
// Each lane decodes one instruction per cycle into operand fields, an ALU op and a
// packed control word. It holds one output entry (main) plus a one-entry skid buffer
// under valid/ready backpressure. A one-hot per-warp flush drops matching entries.
// Ports (lane k uses slice [k*W +: W] of every packed bus):
//   clk, rst_n            clock, asynchronous active-low reset
//   in_warp/instr/pcplus4 fetched instruction, one-hot warp (all-zero = bubble)
//   in_ready              lane can accept this cycle (registered)
//   flush_warp            warps whose entries are killed this cycle
//   out_valid/out_ready   output handshake
//   out_warp/instr/pcplus4, out_src1/src2/dst/imm/target, out_aluop, out_ctrl
module decode_pipe_nlane #(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned NUM_WARPS = 8,
  parameter int unsigned CTRL_W    = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_LANES*NUM_WARPS-1:0] in_warp,
  input  logic [NUM_LANES*32-1:0]        in_instr,
  input  logic [NUM_LANES*32-1:0]        in_pcplus4,
  output logic [NUM_LANES-1:0]           in_ready,
  input  logic [NUM_WARPS-1:0]           flush_warp,
  output logic [NUM_LANES-1:0]           out_valid,
  input  logic [NUM_LANES-1:0]           out_ready,
  output logic [NUM_LANES*NUM_WARPS-1:0] out_warp,
  output logic [NUM_LANES*32-1:0]        out_instr,
  output logic [NUM_LANES*32-1:0]        out_pcplus4,
  output logic [NUM_LANES*5-1:0]         out_src1,
  output logic [NUM_LANES*5-1:0]         out_src2,
  output logic [NUM_LANES*5-1:0]         out_dst,
  output logic [NUM_LANES*16-1:0]        out_imm,
  output logic [NUM_LANES*32-1:0]        out_target,
  output logic [NUM_LANES*4-1:0]         out_aluop,
  output logic [NUM_LANES*CTRL_W-1:0]    out_ctrl
);

  localparam int unsigned NW = NUM_WARPS;
  localparam int unsigned IW = 32;
  localparam int unsigned AW = 4;

  localparam int unsigned C_REGW  = 0;
  localparam int unsigned C_MEMW  = 1;
  localparam int unsigned C_MEMR  = 2;
  localparam int unsigned C_SHARE = 3;
  localparam int unsigned C_SRC1V = 4;
  localparam int unsigned C_SRC2V = 5;
  localparam int unsigned C_IMMV  = 6;
  localparam int unsigned C_BEQ   = 7;
  localparam int unsigned C_BLT   = 8;
  localparam int unsigned C_JMP   = 9;
  localparam int unsigned C_CALL  = 10;
  localparam int unsigned C_RET   = 11;
  localparam int unsigned C_EXIT  = 12;
  localparam int unsigned C_DOTS  = 13;
  localparam int unsigned C_ILL   = 14;

  // R-type funct -> ALU op; 4'hF marks an unlisted funct.
  function automatic logic [AW-1:0] funct_aluop(input logic [5:0] funct);
    logic [AW-1:0] a;
    case (funct)
      6'b100000: a = 4'h0;
      6'b100010: a = 4'h1;
      6'b011000: a = 4'h2;
      6'b100100: a = 4'h3;
      6'b100101: a = 4'h4;
      6'b100110: a = 4'h5;
      6'b000010: a = 4'h6;
      6'b000000: a = 4'h7;
      default:   a = 4'hF;
    endcase
    return a;
  endfunction

  // Variant-bit opcodes compare {op[5], op[3:0]}; CALL/RET/EXIT compare all six bits.
  function automatic logic [CTRL_W-1:0] dec_ctrl(input logic [5:0] op, input logic [5:0] funct);
    logic [CTRL_W-1:0] c;
    logic [4:0] v;
    logic is_r, alu_imm, ld, lds, sw, sws, beq, blt, jmp, call, ret, ext, legal;
    v       = {op[5], op[3:0]};
    is_r    = (v == 5'b0_0000);
    alu_imm = (v == 5'b0_1000) | (v == 5'b0_1100) | (v == 5'b0_1101) | (v == 5'b0_1110);
    ld      = (v == 5'b1_0011);
    lds     = (v == 5'b1_0111);
    sw      = (v == 5'b1_1011);
    sws     = (v == 5'b1_1111);
    beq     = (v == 5'b0_0100);
    blt     = (v == 5'b0_0111);
    jmp     = (v == 5'b0_0010);
    call    = (op == 6'b000011);
    ret     = (op == 6'b000110);
    ext     = (op == 6'b100001);
    legal   = (is_r & (funct_aluop(funct) != 4'hF)) | alu_imm | ld | lds | sw | sws |
              beq | blt | jmp | call | ret | ext;
    c = '0;
    // An illegal instruction carries only the Illegal flag.
    if (!legal) begin
      c[C_ILL] = 1'b1;
    end else begin
      c[C_REGW]  = is_r | alu_imm | ld | lds;
      c[C_MEMW]  = sw | sws;
      c[C_MEMR]  = ld | lds;
      c[C_SHARE] = lds | sws;
      c[C_SRC1V] = is_r | alu_imm | ld | lds | sw | sws | beq | blt;
      c[C_SRC2V] = is_r | alu_imm | ld | lds | sw | sws | beq | blt;
      c[C_IMMV]  = alu_imm;
      c[C_BEQ]   = beq;
      c[C_BLT]   = blt;
      c[C_JMP]   = jmp;
      c[C_CALL]  = call;
      c[C_RET]   = ret;
      c[C_EXIT]  = ext;
      c[C_DOTS]  = op[4];
    end
    return c;
  endfunction

  function automatic logic [AW-1:0] dec_aluop(input logic [5:0] op, input logic [5:0] funct);
    return (op[5] == 1'b0 && op[3:0] == 4'b0000) ? funct_aluop(funct) : 4'h0;
  endfunction

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [NW-1:0]     iw;
    logic [IW-1:0]     ii, ip;
    logic              main_v, skid_v, rdy_q;
    logic [NW-1:0]     main_warp, skid_warp;
    logic [IW-1:0]     main_instr, main_pc, skid_instr, skid_pc;
    logic [CTRL_W-1:0] main_ctrl;
    logic [AW-1:0]     main_aluop;
    logic              main_v_n, skid_v_n, load_main, load_skid, sel_skid;
    logic              main_free, skid_live, inc_live;
    logic [NW-1:0]     ld_warp;
    logic [IW-1:0]     ld_instr, ld_pc;

    assign iw = in_warp[k*NW +: NW];
    assign ii = in_instr[k*IW +: IW];
    assign ip = in_pcplus4[k*IW +: IW];

    // Next-state: main refills from skid first (FIFO order), otherwise from input;
    // a flushed main frees the slot just like a taken one.
    always_comb begin
      main_v_n  = main_v;
      skid_v_n  = skid_v;
      load_main = 1'b0;
      load_skid = 1'b0;
      sel_skid  = 1'b0;
      main_free = ~main_v | out_ready[k] | (|(main_warp & flush_warp));
      skid_live = skid_v & ~(|(skid_warp & flush_warp));
      inc_live  = rdy_q & (|iw) & ~(|(iw & flush_warp));
      if (main_free) begin
        main_v_n  = skid_live | inc_live;
        load_main = skid_live | inc_live;
        sel_skid  = skid_live;
        skid_v_n  = 1'b0;
      end else if (skid_v) begin
        skid_v_n  = skid_live;
      end else begin
        skid_v_n  = inc_live;
        load_skid = inc_live;
      end
      ld_warp  = sel_skid ? skid_warp  : iw;
      ld_instr = sel_skid ? skid_instr : ii;
      ld_pc    = sel_skid ? skid_pc    : ip;
    end

    // Pipeline and skid registers; main data only changes when a new entry loads.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        main_v     <= 1'b0;
        skid_v     <= 1'b0;
        rdy_q      <= 1'b0;
        main_warp  <= '0;
        main_instr <= '0;
        main_pc    <= '0;
        main_ctrl  <= '0;
        main_aluop <= '0;
        skid_warp  <= '0;
        skid_instr <= '0;
        skid_pc    <= '0;
      end else begin
        main_v <= main_v_n;
        skid_v <= skid_v_n;
        rdy_q  <= ~skid_v_n;
        if (load_main) begin
          main_warp  <= ld_warp;
          main_instr <= ld_instr;
          main_pc    <= ld_pc;
          main_ctrl  <= dec_ctrl(ld_instr[31:26], ld_instr[5:0]);
          main_aluop <= dec_aluop(ld_instr[31:26], ld_instr[5:0]);
        end
        if (load_skid) begin
          skid_warp  <= iw;
          skid_instr <= ii;
          skid_pc    <= ip;
        end
      end
    end

    assign in_ready[k]                  = rdy_q;
    assign out_valid[k]                 = main_v;
    assign out_warp[k*NW +: NW]         = main_warp;
    assign out_instr[k*IW +: IW]        = main_instr;
    assign out_pcplus4[k*IW +: IW]      = main_pc;
    assign out_src1[k*5 +: 5]           = main_instr[25:21];
    assign out_src2[k*5 +: 5]           = main_instr[20:16];
    assign out_dst[k*5 +: 5]            = main_instr[15:11];
    assign out_imm[k*16 +: 16]          = main_instr[15:0];
    assign out_target[k*IW +: IW]       = {6'b0, main_instr[25:0]};
    assign out_aluop[k*AW +: AW]        = main_aluop;
    assign out_ctrl[k*CTRL_W +: CTRL_W] = main_ctrl;
  end

endmodule

// File: tb/tb_decode_pipe_nlane.sv
// Self-checking bench for decode_pipe_nlane (2 lanes, 8 warps, 16-bit ctrl):
// a decode vector table streamed through both lanes, plus hand-written
// backpressure, flush and reset sequences.
module tb_decode_pipe_nlane;
  localparam int unsigned NL = 2;
  localparam int unsigned NW = 8;
  localparam int unsigned CW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NL*NW-1:0] in_warp;
  logic [NL*32-1:0] in_instr, in_pcplus4;
  logic [NL-1:0]    in_ready;
  logic [NW-1:0]    flush_warp;
  logic [NL-1:0]    out_valid, out_ready;
  logic [NL*NW-1:0] out_warp;
  logic [NL*32-1:0] out_instr, out_pcplus4, out_target;
  logic [NL*5-1:0]  out_src1, out_src2, out_dst;
  logic [NL*16-1:0] out_imm;
  logic [NL*4-1:0]  out_aluop;
  logic [NL*CW-1:0] out_ctrl;

  decode_pipe_nlane #(.NUM_LANES(NL), .NUM_WARPS(NW), .CTRL_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_warp(in_warp), .in_instr(in_instr),
    .in_pcplus4(in_pcplus4), .in_ready(in_ready), .flush_warp(flush_warp),
    .out_valid(out_valid), .out_ready(out_ready), .out_warp(out_warp),
    .out_instr(out_instr), .out_pcplus4(out_pcplus4), .out_src1(out_src1),
    .out_src2(out_src2), .out_dst(out_dst), .out_imm(out_imm),
    .out_target(out_target), .out_aluop(out_aluop), .out_ctrl(out_ctrl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [15:0] ctrl;
    logic [3:0]  aluop;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic [4:0]  dst;
    logic [15:0] imm;
    logic [31:0] target;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int lane, input logic [7:0] w, input logic [31:0] ins, input logic [31:0] pc);
    in_warp[lane*NW +: NW]     = w;
    in_instr[lane*32 +: 32]    = ins;
    in_pcplus4[lane*32 +: 32]  = pc;
  endtask

  logic [31:0] ia, ib, ic;

  initial begin
    vecs[0]  = '{32'h20220005, 16'h0071, 4'h0, 5'd1, 5'd2, 5'd0, 16'h0005, 32'h00220005}; // ADDI
    vecs[1]  = '{32'hF8000000, 16'h4000, 4'h0, 5'd0, 5'd0, 5'd0, 16'h0000, 32'h00000000}; // illegal opcode
    vecs[2]  = '{32'h0C000040, 16'h0400, 4'h0, 5'd0, 5'd0, 5'd0, 16'h0040, 32'h00000040}; // CALL
    vecs[3]  = '{32'h00221820, 16'h0031, 4'h0, 5'd1, 5'd2, 5'd3, 16'h1820, 32'h00221820}; // ADD
    vecs[4]  = '{32'h00221818, 16'h0031, 4'h2, 5'd1, 5'd2, 5'd3, 16'h1818, 32'h00221818}; // MUL
    vecs[5]  = '{32'h0022183F, 16'h4000, 4'hF, 5'd1, 5'd2, 5'd3, 16'h183F, 32'h0022183F}; // bad funct
    vecs[6]  = '{32'hCC000008, 16'h2035, 4'h0, 5'd0, 5'd0, 5'd0, 16'h0008, 32'h00000008}; // LD.s
    vecs[7]  = '{32'h9C000008, 16'h003D, 4'h0, 5'd0, 5'd0, 5'd0, 16'h0008, 32'h00000008}; // LDS
    vecs[8]  = '{32'hBC000000, 16'h003A, 4'h0, 5'd0, 5'd0, 5'd0, 16'h0000, 32'h00000000}; // SWS
    vecs[9]  = '{32'h1C000000, 16'h0130, 4'h0, 5'd0, 5'd0, 5'd0, 16'h0000, 32'h00000000}; // BLT
    vecs[10] = '{32'h84000000, 16'h1000, 4'h0, 5'd0, 5'd0, 5'd0, 16'h0000, 32'h00000000}; // EXIT
    vecs[11] = '{32'hC4000000, 16'h4000, 4'h0, 5'd0, 5'd0, 5'd0, 16'h0000, 32'h00000000}; // EXIT|bit4: illegal
    vecs[12] = '{32'h48000010, 16'h2200, 4'h0, 5'd0, 5'd0, 5'd0, 16'h0010, 32'h00000010}; // J.s
    vecs[13] = '{32'h18000000, 16'h0800, 4'h0, 5'd0, 5'd0, 5'd0, 16'h0000, 32'h00000000}; // RET
    vecs[14] = '{32'h78000000, 16'h2071, 4'h0, 5'd0, 5'd0, 5'd0, 16'h0000, 32'h00000000}; // XORI.s
    vecs[15] = '{32'h00221822, 16'h0031, 4'h1, 5'd1, 5'd2, 5'd3, 16'h1822, 32'h00221822}; // SUB
    vecs[16] = '{32'h00221800, 16'h0031, 4'h7, 5'd1, 5'd2, 5'd3, 16'h1800, 32'h00221800}; // SHL

    rst_n = 1'b0;
    in_warp = '0; in_instr = '0; in_pcplus4 = '0;
    flush_warp = '0; out_ready = '0;

    // Reset state
    repeat (2) tick();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_ctrl", out_ctrl, 32'h0);
    chk("rst_instr0", out_instr[31:0], 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_pre_edge", 32'(in_ready), 32'h0);
    tick();
    chk("rel_in_ready_post_edge", 32'(in_ready), 32'h3);

    // Decode table streamed at full rate; lane1 walks the table backwards.
    out_ready = 2'b11;
    for (int i = 0; i < NV; i++) begin
      drive(0, 8'h04, vecs[i].instr, 32'h1000 + 32'(i) * 4);
      drive(1, 8'h10, vecs[NV-1-i].instr, 32'h2000 + 32'(i) * 4);
      tick();
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'h3);
      chk($sformatf("v%0d_warp0", i), 32'(out_warp[7:0]), 32'h04);
      chk($sformatf("v%0d_ctrl0", i), 32'(out_ctrl[15:0]), 32'(vecs[i].ctrl));
      chk($sformatf("v%0d_aluop0", i), 32'(out_aluop[3:0]), 32'(vecs[i].aluop));
      chk($sformatf("v%0d_src1", i), 32'(out_src1[4:0]), 32'(vecs[i].src1));
      chk($sformatf("v%0d_src2", i), 32'(out_src2[4:0]), 32'(vecs[i].src2));
      chk($sformatf("v%0d_dst", i), 32'(out_dst[4:0]), 32'(vecs[i].dst));
      chk($sformatf("v%0d_imm", i), 32'(out_imm[15:0]), 32'(vecs[i].imm));
      chk($sformatf("v%0d_target", i), out_target[31:0], vecs[i].target);
      chk($sformatf("v%0d_pc0", i), out_pcplus4[31:0], 32'h1000 + 32'(i) * 4);
      chk($sformatf("v%0d_ctrl1", i), 32'(out_ctrl[31:16]), 32'(vecs[NV-1-i].ctrl));
      chk($sformatf("v%0d_aluop1", i), 32'(out_aluop[7:4]), 32'(vecs[NV-1-i].aluop));
      chk($sformatf("v%0d_instr1", i), out_instr[63:32], vecs[NV-1-i].instr);
    end

    // Lane independence: lane0 ADD, lane1 MUL in the same cycle.
    drive(0, 8'h01, 32'h00221820, 32'h0);
    drive(1, 8'h02, 32'h00221818, 32'h0);
    tick();
    chk("indep_aluop0", 32'(out_aluop[3:0]), 32'h0);
    chk("indep_aluop1", 32'(out_aluop[7:4]), 32'h2);
    in_warp = '0;
    tick();
    chk("drain_valid", 32'(out_valid), 32'h0);

    // Backpressure on lane0: A held, B to skid, C retried until accepted.
    ia = 32'h20010001; ib = 32'h20010002; ic = 32'h20010003;
    out_ready = 2'b00;
    drive(0, 8'h01, ia, 32'hA);
    tick();
    chk("bp1_instr", out_instr[31:0], ia);
    chk("bp1_in_ready", 32'(in_ready[0]), 32'h1);
    drive(0, 8'h01, ib, 32'hB);
    tick();
    chk("bp2_instr", out_instr[31:0], ia);
    chk("bp2_in_ready", 32'(in_ready[0]), 32'h0);
    drive(0, 8'h01, ic, 32'hC);
    tick();
    chk("bp3_instr", out_instr[31:0], ia);
    chk("bp3_pc", out_pcplus4[31:0], 32'hA);
    chk("bp3_in_ready", 32'(in_ready[0]), 32'h0);
    chk("bp3_valid", 32'(out_valid[0]), 32'h1);
    out_ready = 2'b11;
    tick();
    chk("bp4_instr_b", out_instr[31:0], ib);
    chk("bp4_in_ready", 32'(in_ready[0]), 32'h1);
    tick();
    chk("bp5_instr_c", out_instr[31:0], ic);
    chk("bp5_valid", 32'(out_valid[0]), 32'h1);
    in_warp = '0;
    tick();
    chk("bp6_valid", 32'(out_valid[0]), 32'h0);

    // Flush main (warp2) while skid (warp5) survives and moves up.
    out_ready = 2'b00;
    drive(0, 8'h04, 32'h20000011, 32'h0);
    tick();
    drive(0, 8'h20, 32'h20000022, 32'h0);
    tick();
    chk("fl_skid_full", 32'(in_ready[0]), 32'h0);
    in_warp = '0;
    flush_warp = 8'h04;
    tick();
    flush_warp = '0;
    chk("fl_valid", 32'(out_valid[0]), 32'h1);
    chk("fl_warp", 32'(out_warp[7:0]), 32'h20);
    chk("fl_instr", out_instr[31:0], 32'h20000022);
    chk("fl_in_ready", 32'(in_ready[0]), 32'h1);
    out_ready = 2'b11;
    tick();
    chk("fl_drain", 32'(out_valid[0]), 32'h0);

    // Flushed incoming instruction never appears.
    drive(0, 8'h08, 32'h20000033, 32'h0);
    flush_warp = 8'h08;
    tick();
    flush_warp = '0;
    in_warp = '0;
    chk("fl_incoming", 32'(out_valid[0]), 32'h0);

    // Reset asserted with both entries full.
    out_ready = 2'b00;
    drive(0, 8'h01, 32'h20000044, 32'h0);
    tick();
    drive(0, 8'h01, 32'h20000055, 32'h0);
    tick();
    in_warp = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'h0);
    chk("mrst_in_ready", 32'(in_ready), 32'h0);
    chk("mrst_instr", out_instr[31:0], 32'h0);
    rst_n = 1'b1;
    #1;
    chk("mrst_rel_in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("mrst_edge_in_ready", 32'(in_ready), 32'h3);
    chk("mrst_edge_valid", 32'(out_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
